// File: rtl/cheri_dmem_resp_pkg.sv
//------------------------------------------------------------------------------
// cheri_dmem_resp_pkg
// Shared types and constants for the CHERIoT data-memory responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cheri_dmem_resp_pkg;

    localparam int TagBit   = 32;
    localparam int RamWordW = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_CAP_BE = 2'd3
    } err_cause_e;

endpackage

`default_nettype wire

// File: rtl/cheri_dmem_responder.sv
//------------------------------------------------------------------------------
// cheri_dmem_responder
// Memory-side req/gnt/rvalid responder with wait states, range/cap checks and
// a tagged single-port SRAM interface.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cheri_dmem_responder
    import cheri_dmem_resp_pkg::*;
#(
    parameter logic [31:0] MemBase    = 32'h2000_0000,
    parameter logic [31:0] MemSize    = 32'h0004_0000,
    parameter int unsigned AddrW      = 16,
    parameter int unsigned WaitStates = 0
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    input  logic                data_we_i,
    input  logic                data_is_cap_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [32:0]         data_wdata_i,
    output logic [32:0]         data_rdata_o,
    output logic                data_err_o,
    output logic                ram_cs_o,
    output logic                ram_we_o,
    output logic [4:0]          ram_bwe_o,
    output logic [AddrW-1:0]    ram_addr_o,
    output logic [32:0]         ram_wdata_o,
    input  logic [32:0]         ram_rdata_i
);

    localparam logic [2:0] WaitInit = (WaitStates == 0) ? 3'd0 : 3'(WaitStates - 1);

    state_e      state_q, state_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        load_q, load_d;
    logic        cap_q, cap_d;

    logic [31:0] offset;
    err_cause_e  err_cause;
    logic        gnt;
    logic        access;

    // Window decode uses wrapping subtraction so addresses below MemBase miss.
    always_comb begin
        offset = data_addr_i - MemBase;
        if (!(offset < MemSize)) begin
            err_cause = ERR_RANGE;
        end else if (data_is_cap_i && (data_addr_i[1:0] != 2'b00)) begin
            err_cause = ERR_ALIGN;
        end else if (data_is_cap_i && data_we_i && (data_be_i != 4'hF)) begin
            err_cause = ERR_CAP_BE;
        end else begin
            err_cause = ERR_NONE;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (data_req_i) begin
                    if (WaitStates == 0) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WaitInit;
                    end
                end
            end
            ST_WAIT: begin
                if (!data_req_i) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 3'd0) begin
                    gnt = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Grant is forced low while reset is held so every output reads 0.
        gnt = gnt & rstn_i;
        if (gnt) begin
            state_d = ST_RESP;
        end
    end

    always_comb begin
        access      = gnt && (err_cause == ERR_NONE);
        ram_cs_o    = access;
        ram_we_o    = access & data_we_i;
        ram_addr_o  = '0;
        ram_bwe_o   = '0;
        ram_wdata_o = '0;
        if (access) begin
            ram_addr_o = offset[AddrW+1:2];
        end
        if (access && data_we_i) begin
            // Any non-cap byte write clears the tag; an empty mask leaves it alone.
            ram_bwe_o   = {data_is_cap_i | (data_be_i != 4'h0), data_be_i};
            ram_wdata_o = {data_is_cap_i & data_wdata_i[TagBit], data_wdata_i[TagBit-1:0]};
        end
    end

    always_comb begin
        rvalid_d = gnt;
        err_d    = gnt && (err_cause != ERR_NONE);
        load_d   = access && !data_we_i;
        cap_d    = gnt && data_is_cap_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= 3'd0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            load_q   <= load_d;
            cap_q    <= cap_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = load_q ? {cap_q & ram_rdata_i[TagBit], ram_rdata_i[TagBit-1:0]}
                                  : '0;

endmodule

`default_nettype wire

// File: tb/tb_cheri_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_cheri_dmem_responder
// Scoreboard bench: zero-wait instance with random traffic, three-wait instance
// with directed timing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cheri_dmem_responder;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] SIZE = 32'h0004_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- zero-wait instance ----------------
    logic        req0 = 0, we0 = 0, cap0 = 0;
    logic [3:0]  be0 = 0;
    logic [31:0] addr0 = 0;
    logic [32:0] wdata0 = 0;
    wire         gnt0, rvalid0, err0, ram_cs0, ram_we0;
    wire  [32:0] rdata0, ram_wdata0;
    wire  [4:0]  ram_bwe0;
    wire  [15:0] ram_addr0;
    logic [32:0] ram_rdata0 = 0;

    cheri_dmem_responder #(.MemBase(BASE), .MemSize(SIZE), .AddrW(16), .WaitStates(0)) u_dut0 (
        .clk_i(clk), .rstn_i(rst_n),
        .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
        .data_we_i(we0), .data_is_cap_i(cap0), .data_be_i(be0),
        .data_addr_i(addr0), .data_wdata_i(wdata0),
        .data_rdata_o(rdata0), .data_err_o(err0),
        .ram_cs_o(ram_cs0), .ram_we_o(ram_we0), .ram_bwe_o(ram_bwe0),
        .ram_addr_o(ram_addr0), .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
    );

    // ---------------- three-wait instance ----------------
    logic        req3 = 0, we3 = 0, cap3 = 0;
    logic [3:0]  be3 = 0;
    logic [31:0] addr3 = 0;
    logic [32:0] wdata3 = 0;
    wire         gnt3, rvalid3, err3, ram_cs3, ram_we3;
    wire  [32:0] rdata3, ram_wdata3;
    wire  [4:0]  ram_bwe3;
    wire  [15:0] ram_addr3;
    logic [32:0] ram_rdata3 = 0;

    cheri_dmem_responder #(.MemBase(BASE), .MemSize(SIZE), .AddrW(16), .WaitStates(3)) u_dut3 (
        .clk_i(clk), .rstn_i(rst_n),
        .data_req_i(req3), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
        .data_we_i(we3), .data_is_cap_i(cap3), .data_be_i(be3),
        .data_addr_i(addr3), .data_wdata_i(wdata3),
        .data_rdata_o(rdata3), .data_err_o(err3),
        .ram_cs_o(ram_cs3), .ram_we_o(ram_we3), .ram_bwe_o(ram_bwe3),
        .ram_addr_o(ram_addr3), .ram_wdata_o(ram_wdata3), .ram_rdata_i(ram_rdata3)
    );

    // Tagged SRAM macros: masked writes, registered read.
    logic [32:0] mem0 [0:65535];
    logic [32:0] mem3 [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem0[i] = '0;
            mem3[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (ram_cs0) begin
            if (ram_we0) begin
                for (int b = 0; b < 4; b++)
                    if (ram_bwe0[b]) mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
                if (ram_bwe0[4]) mem0[ram_addr0][32] <= ram_wdata0[32];
            end else begin
                ram_rdata0 <= mem0[ram_addr0];
            end
        end
        if (ram_cs3) begin
            if (ram_we3) begin
                for (int b = 0; b < 4; b++)
                    if (ram_bwe3[b]) mem3[ram_addr3][8*b +: 8] <= ram_wdata3[8*b +: 8];
                if (ram_bwe3[4]) mem3[ram_addr3][32] <= ram_wdata3[32];
            end else begin
                ram_rdata3 <= mem3[ram_addr3];
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [32:0] rdata;
        logic        err;
        int          gcyc;
    } exp_t;

    exp_t        sb_q[$];
    bit   [32:0] ref_mem [int unsigned];

    task automatic txn0(input bit we, input bit cap, input bit [3:0] be,
                        input bit [31:0] addr, input bit [32:0] wd);
        exp_t        e;
        int          waited;
        bit          err;
        bit   [31:0] off;
        int unsigned idx;
        bit   [32:0] w;
        req0 = 1; we0 = we; cap0 = cap; be0 = be; addr0 = addr; wdata0 = wd;
        waited = 0;
        @(negedge clk);
        while (!gnt0 && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        check("gnt_latency", waited, 0);
        if (gnt0) begin
            off = addr - BASE;
            err = !(off < SIZE) || (cap && (addr % 4 != 0)) || (cap && we && be != 4'hF);
            check("ram_cs", ram_cs0, !err);
            check("ram_we", ram_we0, we && !err);
            idx = off / 4;
            w = ref_mem.exists(idx) ? ref_mem[idx] : '0;
            e.err  = err;
            e.gcyc = cyc;
            e.rdata = '0;
            if (!err && we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                if (cap) w[32] = wd[32];
                else if (be != 0) w[32] = 1'b0;
                ref_mem[idx] = w;
            end else if (!err) begin
                e.rdata = {cap ? w[32] : 1'b0, w[31:0]};
            end
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        req0 = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) check("cs_implies_gnt", ram_cs0 & ~gnt0, 1'b0);
        if (sb_q.size() > 0 && sb_q[0].gcyc + 1 < cyc) begin
            n_checks++;
            $display("FAIL missing_rvalid: rvalid=0 expected 1 (grant cycle %0d)", sb_q[0].gcyc);
            void'(sb_q.pop_front());
        end
        if (rvalid0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rvalid: rvalid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("rvalid_cycle", cyc, e.gcyc + 1);
                check("rdata", rdata0, e.rdata);
                check("err", err0, e.err);
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_gnt0"}, gnt0, 0);       check({tag, "_rvalid0"}, rvalid0, 0);
        check({tag, "_rdata0"}, rdata0, 0);   check({tag, "_err0"}, err0, 0);
        check({tag, "_cs0"}, ram_cs0, 0);     check({tag, "_we0"}, ram_we0, 0);
        check({tag, "_bwe0"}, ram_bwe0, 0);   check({tag, "_addr0"}, ram_addr0, 0);
        check({tag, "_wdata0"}, ram_wdata0, 0);
        check({tag, "_gnt3"}, gnt3, 0);       check({tag, "_rvalid3"}, rvalid3, 0);
        check({tag, "_cs3"}, ram_cs3, 0);     check({tag, "_rdata3"}, rdata3, 0);
    endtask

    // ---------------- three-wait directed tasks ----------------
    task automatic txn3(input bit we, input bit cap, input bit [3:0] be, input bit [31:0] addr,
                        input bit [32:0] wd, input bit [32:0] exp_rd, input bit exp_err);
        req3 = 1; we3 = we; cap3 = cap; be3 = be; addr3 = addr; wdata3 = wd;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ws3_gnt", gnt3, k == 3);
            check("ws3_cs", ram_cs3, (k == 3) && !exp_err);
            check("ws3_rvalid", rvalid3, k == 4);
            if (k == 4) begin
                check("ws3_rdata", rdata3, exp_rd);
                check("ws3_err", err3, exp_err);
            end
            @(posedge clk); #1;
            if (k == 3) req3 = 0;
        end
    endtask

    task automatic drop3(input bit [31:0] addr);
        req3 = 1; we3 = 0; cap3 = 0; be3 = 4'hF; addr3 = addr; wdata3 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("drop_gnt", gnt3, 0);
            check("drop_cs", ram_cs3, 0);
            check("drop_rvalid", rvalid3, 0);
            @(posedge clk); #1;
            if (k == 0) req3 = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit   [31:0] a;
        bit   [3:0]  be;
        bit          we, cap;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Cap store/load round trip, then tag clearing by a byte store
        txn0(1, 1, 4'hF, 32'h2000_0010, {1'b1, 32'hDEAD_BEEF});
        txn0(0, 1, 4'hF, 32'h2000_0010, '0);
        txn0(1, 0, 4'b0001, 32'h2000_0010, 33'h55);
        txn0(0, 1, 4'hF, 32'h2000_0010, '0);
        txn0(1, 1, 4'hF, 32'h2000_0014, {1'b1, 32'hCAFE_F00D});
        txn0(0, 0, 4'hF, 32'h2000_0014, '0);
        txn0(1, 0, 4'h0, 32'h2000_0014, 33'h0_1111_1111);
        txn0(0, 1, 4'hF, 32'h2000_0014, '0);

        // Error cases
        txn0(0, 0, 4'hF, BASE + SIZE, '0);
        txn0(0, 1, 4'hF, 32'h2000_0012, '0);
        txn0(1, 1, 4'h7, 32'h2000_0020, {1'b1, 32'h1234_5678});
        txn0(0, 0, 4'hF, BASE - 4, '0);
        txn0(0, 0, 4'hF, BASE + SIZE - 4, '0);

        // Eight back-to-back loads
        for (int i = 0; i < 8; i++) txn0(0, i % 2, 4'hF, BASE + 32'h10 + 4 * i, '0);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE + SIZE + $urandom_range(0, 15);
                1:       a = BASE - 1 - $urandom_range(0, 15);
                2:       a = BASE + SIZE - 4;
                default: a = BASE + 4 * $urandom_range(0, 15)
                             + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            endcase
            we  = $urandom_range(0, 1);
            cap = $urandom_range(0, 1);
            be  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            txn0(we, cap, be, a, {1'($urandom_range(0, 1)), 32'($urandom)});
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        // Reset in the cycle after a grant drops the response
        req0 = 1; we0 = 0; cap0 = 1; be0 = 4'hF; addr0 = 32'h2000_0010; wdata0 = '0;
        @(negedge clk);
        check("pre_reset_gnt", gnt0, 1);
        @(posedge clk); #1;
        req0 = 0;
        rst_n = 0;
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        txn0(0, 1, 4'hF, 32'h2000_0010, '0);
        txn0(0, 0, 4'hF, 32'h2000_0014, '0);

        // Three-wait instance
        txn3(1, 1, 4'hF, BASE + 32'h40, {1'b1, 32'h1234_5678}, '0, 0);
        txn3(0, 1, 4'hF, BASE + 32'h40, '0, {1'b1, 32'h1234_5678}, 0);
        drop3(BASE + 32'h40);
        txn3(0, 0, 4'hF, BASE + 32'h40, '0, {1'b0, 32'h1234_5678}, 0);
        txn3(0, 0, 4'hF, BASE + SIZE, '0, '0, 1);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
